// File: rtl/asyn_fifo_read_ctrl_lvl.sv
// Read-domain controller for the async FIFO: write-pointer synchroniser, registered level,
// almost-empty flag, underflow pulse. Optional sticky underflow under READ_UNDERFLOW_STICKY_EN.
module asyn_fifo_read_ctrl_lvl #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  read_clk,
  input  logic                  read_rst_n,
  input  logic                  read_ena,
  input  logic [ADDR_WIDTH:0]   write_ptr,
  input  logic [ADDR_WIDTH:0]   aempty_thresh,
`ifdef READ_UNDERFLOW_STICKY_EN
  input  logic                  read_err_clr,
  output logic                  read_underflow_sticky,
`endif
  output logic [ADDR_WIDTH:0]   read_ptr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_empty_reg,
  output logic                  read_aempty,
  output logic [ADDR_WIDTH:0]   read_level,
  output logic                  read_underflow
);

  logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH:0] sync_wptr;
  logic [ADDR_WIDTH:0] wbin_sync;

  logic [ADDR_WIDTH:0] rbin_q, rbin_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                empty_q, empty_d;
  logic                aempty_q, aempty_d;
  logic                underflow_q, underflow_d;
  logic                fire;

  // Plain flop chain; no logic between stages.
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= write_ptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_wptr = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    wbin_sync = '0;
    for (int i = 0; i <= int'(ADDR_WIDTH); i++) wbin_sync[i] = ^(sync_wptr >> i);
  end

  always_comb begin
    fire        = read_ena & ~empty_q;
    rbin_d      = rbin_q + {{ADDR_WIDTH{1'b0}}, fire};
    rptr_d      = (rbin_d >> 1) ^ rbin_d;
    empty_d     = (rptr_d == sync_wptr);
    level_d     = wbin_sync - rbin_d;
    aempty_d    = (level_d <= aempty_thresh);
    underflow_d = read_ena & empty_q;
  end

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      rbin_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
      underflow_q <= underflow_d;
    end
  end

  assign read_ptr       = rptr_q;
  assign read_addr      = rbin_q[ADDR_WIDTH-1:0];
  assign read_empty_reg = empty_q;
  assign read_aempty    = aempty_q;
  assign read_level     = level_q;
  assign read_underflow = underflow_q;

`ifdef READ_UNDERFLOW_STICKY_EN
  logic sticky_q, sticky_d;

  // Set takes priority over clear.
  always_comb begin
    sticky_d = underflow_d | (sticky_q & ~read_err_clr);
  end

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) sticky_q <= 1'b0;
    else             sticky_q <= sticky_d;
  end

  assign read_underflow_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_asyn_fifo_read_ctrl_lvl.sv
// Self-checking bench for asyn_fifo_read_ctrl_lvl: vector table, directed corner sequences and
// random traffic against a word-count reference model.
module tb_asyn_fifo_read_ctrl_lvl;

  localparam int AW = 6;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          read_ena = 1'b0;
  logic [AW:0]   write_ptr;
  logic [AW:0]   aempty_thresh = '0;
  logic [AW:0]   read_ptr;
  logic [AW-1:0] read_addr;
  logic          read_empty_reg, read_aempty, read_underflow;
  logic [AW:0]   read_level;
`ifdef READ_UNDERFLOW_STICKY_EN
  logic          read_err_clr = 1'b0;
  logic          sticky;
`endif

  int unsigned wtot = 0;  // words written since reset
  int unsigned rtot = 0;  // words read since reset
  int unsigned hist[$];   // write counts seen at recent edges
  int unsigned m_level = 0;
  bit          m_empty = 1'b1, m_aempty = 1'b1, m_uf = 1'b0;
  int          tests = 0, fails = 0;

  function automatic logic [AW:0] gray7(input int unsigned n);
    logic [AW:0] b;
    b = (AW+1)'(n % 128);
    return b ^ (b >> 1);
  endfunction

  assign write_ptr = gray7(wtot);

  always #5 clk = ~clk;

  asyn_fifo_read_ctrl_lvl #(.ADDR_WIDTH(AW), .SYNC_STAGES(S)) dut (
    .read_clk       (clk),
    .read_rst_n     (rst_n),
    .read_ena       (read_ena),
    .write_ptr      (write_ptr),
    .aempty_thresh  (aempty_thresh),
`ifdef READ_UNDERFLOW_STICKY_EN
    .read_err_clr   (read_err_clr),
    .read_underflow_sticky (sticky),
`endif
    .read_ptr       (read_ptr),
    .read_addr      (read_addr),
    .read_empty_reg (read_empty_reg),
    .read_aempty    (read_aempty),
    .read_level     (read_level),
    .read_underflow (read_underflow)
  );

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({read_ptr, read_addr, read_level, read_empty_reg, read_aempty, read_underflow});
  endfunction

  function automatic logic [63:0] model_vec();
    return 64'({gray7(rtot), AW'(rtot % 64), (AW+1)'(m_level), m_empty, m_aempty, m_uf});
  endfunction

  // One clock edge: advance the word-count model, then compare all outputs.
  task automatic tick();
    int unsigned sync_cnt;
    bit fire;
    @(posedge clk);
    sync_cnt = (hist.size() == S) ? hist[0] : 0;
    hist.push_back(wtot);
    if (hist.size() > S) void'(hist.pop_front());
    fire    = read_ena && !m_empty;
    m_uf    = read_ena && m_empty;
    rtot    = rtot + int'(fire);
    m_level = sync_cnt - rtot;
    m_empty = (m_level == 0);
    m_aempty = (m_level <= int'(aempty_thresh));
    #1;
    cmp("model", dut_vec(), model_vec());
  endtask

  task automatic model_reset();
    wtot = 0; rtot = 0; hist.delete();
    m_level = 0; m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
  endtask

  task automatic do_reset();
    read_ena = 1'b0;
    model_reset();
    rst_n = 1'b0;
    #3;
    cmp("reset", dut_vec(), 64'({7'd0, 6'd0, 7'd0, 1'b1, 1'b1, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          ena;
    int unsigned   wt;
    logic [AW-1:0] addr;
    logic [AW:0]   ptr;
    logic [AW:0]   lvl;
    logic          e, a, u;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int fall;
    int lvl_at_rise;
    // Four words visible, drained by a held read, then one rejected read (thresh = 1).
    tbl[0] = '{1'b0, 4, 6'd0, 7'd0, 7'd0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 4, 6'd0, 7'd0, 7'd0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4, 6'd0, 7'd0, 7'd4, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 4, 6'd1, 7'd1, 7'd3, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 4, 6'd2, 7'd3, 7'd2, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 4, 6'd3, 7'd2, 7'd1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 4, 6'd4, 7'd6, 7'd0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 4, 6'd4, 7'd6, 7'd0, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 4, 6'd4, 7'd6, 7'd0, 1'b1, 1'b1, 1'b0};

    #1;
    do_reset();

    // Latency of the write-pointer path.
    wtot = 1;
    fall = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (!read_empty_reg) begin fall = i; break; end
    end
    cmp("empty_fall_edges", 64'(fall), 64'd3);
    wtot = 5;
    tick(); tick();
    cmp("level_before_sync", 64'(read_level), 64'd1);
    tick();
    cmp("level_after_sync", 64'(read_level), 64'd5);

    // Vector table.
    do_reset();
    aempty_thresh = 7'd1;
    for (int i = 0; i < 9; i++) begin
      read_ena = tbl[i].ena;
      wtot     = tbl[i].wt;
      tick();
      cmp($sformatf("vec%0d", i), dut_vec(),
          64'({tbl[i].ptr, tbl[i].addr, tbl[i].lvl, tbl[i].e, tbl[i].a, tbl[i].u}));
`ifdef READ_UNDERFLOW_STICKY_EN
      if (i == 7) cmp("sticky_set", 64'(sticky), 64'd1);
`endif
    end
`ifdef READ_UNDERFLOW_STICKY_EN
    cmp("sticky_hold", 64'(sticky), 64'd1);
    read_err_clr = 1'b1;
    tick();
    read_err_clr = 1'b0;
    cmp("sticky_clr", 64'(sticky), 64'd0);
`endif

    // Almost-empty around threshold 3.
    do_reset();
    aempty_thresh = 7'd3;
    wtot = 8;
    tick(); tick(); tick();
    cmp("aempty_level8", 64'({read_level, read_aempty}), 64'({7'd8, 1'b0}));
    read_ena = 1'b1;
    lvl_at_rise = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (read_aempty && lvl_at_rise < 0) lvl_at_rise = int'(read_level);
    end
    cmp("aempty_rise_level", 64'(lvl_at_rise), 64'd3);
    read_ena = 1'b0;
    for (int i = 0; i < 4; i++) begin wtot++; tick(); end
    tick(); tick(); tick();
    cmp("aempty_fall", 64'({read_level, read_aempty}), 64'({7'd4, 1'b0}));

    // Wrap: 130 words in bursts of 10.
    do_reset();
    aempty_thresh = 7'd2;
    for (int b = 0; b < 13; b++) begin
      read_ena = 1'b0;
      for (int i = 0; i < 10; i++) begin wtot++; tick(); end
      read_ena = 1'b1;
      for (int i = 0; i < 16; i++) tick();
    end
    read_ena = 1'b0;
    tick();
    cmp("wrap_ptr", 64'(read_ptr), 64'd3);
    cmp("wrap_empty", 64'({read_empty_reg, read_level}), 64'({1'b1, 7'd0}));

    // Random traffic, writer obeys full against true occupancy.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ((c % 200) == 0) aempty_thresh = 7'($urandom_range(0, 64));
      if ($urandom_range(0, 99) < 45 && (wtot - rtot) < 64) wtot++;
      read_ena = ($urandom_range(0, 99) < 50);
      tick();
    end

    // Reset mid-burst at level 20.
    do_reset();
    for (int i = 0; i < 20; i++) begin wtot++; tick(); end
    tick(); tick(); tick();
    cmp("pre_reset_level", 64'(read_level), 64'd20);
    read_ena = 1'b1;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    wtot  = 0;
    #1;
    cmp("async_reset", dut_vec(), 64'({7'd0, 6'd0, 7'd0, 1'b1, 1'b1, 1'b0}));
    read_ena = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
